// File: rtl/core_pkg.sv
// Shared encodings for the multicycle RV32I-subset core: opcodes, control FSM states,
// ALU operation selects and datapath mux encodings.
package core_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_TRAP
    } state_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_REG    = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter; advances by one per retiring instruction and wraps
// modulo 2^CNT_W.
module retire_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle core: sequences fetch, decode, execute, memory
// and write-back over the shared ALU and unified memory, and counts retired instructions.
module multicycle_ctrl
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_en,
    output logic             pc_source,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             funct_sub_mask,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e state_q;
    state_e state_d;
    logic   illegal_q;
    logic   illegal_d;
    logic   retire_inc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        i_or_d         = 1'b0;
        ir_write       = 1'b0;
        pc_en          = 1'b0;
        pc_source      = PC_SRC_ALU;
        alu_src_a      = SRC_A_PC;
        alu_src_b      = SRC_B_REG;
        alu_op         = ALU_OP_ADD;
        funct_sub_mask = 1'b0;
        reg_write      = 1'b0;
        mem_to_reg     = 1'b0;
        retire_inc     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            // PC+4 is written back in the same cycle the instruction lands in IR.
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end

            S_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_R_TYPE:         state_d = S_EXEC_R;
                    OP_I_TYPE:         state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_TRAP;
                endcase
            end

            S_EXEC_R: begin
                alu_src_a = SRC_A_REG;
                alu_op    = ALU_OP_FUNCT;
                state_d   = S_ALUWB;
            end

            S_EXEC_I: begin
                alu_src_a      = SRC_A_REG;
                alu_src_b      = SRC_B_IMM;
                alu_op         = ALU_OP_FUNCT;
                funct_sub_mask = 1'b1;
                state_d        = S_ALUWB;
            end

            S_ALUWB: begin
                reg_write  = 1'b1;
                retire_inc = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMADR: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
                state_d   = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end

            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire_inc = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                retire_inc = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a  = SRC_A_REG;
                alu_op     = ALU_OP_SUB;
                pc_source  = PC_SRC_ALUOUT;
                pc_en      = zero;
                retire_inc = 1'b1;
                state_d    = S_FETCH;
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_IDLE;
        endcase

        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    assign illegal = illegal_q;

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (retire_inc),
        .count   (retired)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a directed vector table, hand-written multi-cycle sequences and
// randomized traffic, all checked against a micro-step queue model of the instruction flow.
module tb_multicycle_ctrl;

    localparam logic [6:0] OPR = 7'b0110011;
    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;
    localparam logic [6:0] OPS = 7'b0100011;
    localparam logic [6:0] OPB = 7'b1100011;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  opcode;
    logic        zero;
    logic        mem_ready;

    logic        mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source;
    logic [1:0]  alu_src_a, alu_src_b, alu_op;
    logic        funct_sub_mask, reg_write, mem_to_reg, illegal;
    logic [31:0] retired;

    logic        w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_pc_en, w_pc_source;
    logic [1:0]  w_alu_src_a, w_alu_src_b, w_alu_op;
    logic        w_funct_sub_mask, w_reg_write, w_mem_to_reg, w_illegal;
    logic [1:0]  w_retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .funct_sub_mask(funct_sub_mask), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .retired(retired)
    );

    multicycle_ctrl #(.CNT_W(2)) dut_w2 (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_read(w_mem_read), .mem_write(w_mem_write), .i_or_d(w_i_or_d), .ir_write(w_ir_write),
        .pc_en(w_pc_en), .pc_source(w_pc_source), .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b),
        .alu_op(w_alu_op), .funct_sub_mask(w_funct_sub_mask), .reg_write(w_reg_write),
        .mem_to_reg(w_mem_to_reg), .illegal(w_illegal), .retired(w_retired)
    );

    typedef struct packed {
        logic       mr, mw, iod, irw, pce, pcs;
        logic [1:0] sa, sb, op;
        logic       fsm, rw, m2r, ill;
    } ctrl_t;

    ctrl_t act, act_w;
    assign act   = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source,
                    alu_src_a, alu_src_b, alu_op, funct_sub_mask, reg_write, mem_to_reg, illegal};
    assign act_w = {w_mem_read, w_mem_write, w_i_or_d, w_ir_write, w_pc_en, w_pc_source,
                    w_alu_src_a, w_alu_src_b, w_alu_op, w_funct_sub_mask, w_reg_write,
                    w_mem_to_reg, w_illegal};

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, a, e);
        end
    endtask

    function automatic ctrl_t ctl(bit mr, mw, iod, irw, pce, pcs, logic [1:0] sa, sb, op,
                                  bit fsm, rw, m2r, ill);
        ctrl_t c;
        c.mr = mr; c.mw = mw; c.iod = iod; c.irw = irw; c.pce = pce; c.pcs = pcs;
        c.sa = sa; c.sb = sb; c.op = op; c.fsm = fsm; c.rw = rw; c.m2r = m2r; c.ill = ill;
        return c;
    endfunction

    // Reference model: a queue of micro-steps for the instruction in flight.
    typedef enum {K_IDLE, K_FETCH, K_DECODE, K_EXEC_R, K_EXEC_I, K_AWB, K_ADR,
                  K_RD, K_LWB, K_WR, K_BR, K_TRAP} kind_e;
    typedef struct {
        kind_e kind;
        ctrl_t c;
        bit    wait_mem;
        bit    retire;
    } step_t;

    step_t       q[$];
    logic [31:0] m_ret;
    bit          m_ill;

    function automatic step_t mk(kind_e k);
        step_t s;
        s.kind = k; s.c = '0; s.wait_mem = 0; s.retire = 0;
        case (k)
            K_FETCH:  begin s.c.mr = 1; s.c.sb = 2'b01; s.wait_mem = 1; end
            K_DECODE: begin s.c.sa = 2'b01; s.c.sb = 2'b10; end
            K_EXEC_R: begin s.c.sa = 2'b10; s.c.op = 2'b10; end
            K_EXEC_I: begin s.c.sa = 2'b10; s.c.sb = 2'b10; s.c.op = 2'b10; s.c.fsm = 1; end
            K_AWB:    begin s.c.rw = 1; s.retire = 1; end
            K_ADR:    begin s.c.sa = 2'b10; s.c.sb = 2'b10; end
            K_RD:     begin s.c.mr = 1; s.c.iod = 1; s.wait_mem = 1; end
            K_LWB:    begin s.c.rw = 1; s.c.m2r = 1; s.retire = 1; end
            K_WR:     begin s.c.mw = 1; s.c.iod = 1; s.wait_mem = 1; s.retire = 1; end
            K_BR:     begin s.c.sa = 2'b10; s.c.op = 2'b01; s.c.pcs = 1; s.retire = 1; end
            default:  ;
        endcase
        return s;
    endfunction

    task automatic model_reset();
        q.delete();
        q.push_back(mk(K_IDLE));
        m_ret = '0;
        m_ill = 0;
    endtask

    function automatic ctrl_t model_expect();
        ctrl_t e;
        if (!reset_n) return '0;
        e = q[0].c;
        if (q[0].kind == K_FETCH) begin e.irw = mem_ready; e.pce = mem_ready; end
        if (q[0].kind == K_BR) e.pce = zero;
        e.ill = m_ill;
        return e;
    endfunction

    task automatic model_advance();
        step_t s;
        if (!reset_n) begin model_reset(); return; end
        s = q[0];
        if (s.kind == K_TRAP) return;
        if (s.wait_mem && !mem_ready) return;
        void'(q.pop_front());
        if (s.retire) m_ret = m_ret + 1;
        if (s.kind == K_FETCH) q.push_back(mk(K_DECODE));
        if (s.kind == K_DECODE) begin
            case (opcode)
                OPR: begin q.push_back(mk(K_EXEC_R)); q.push_back(mk(K_AWB)); end
                OPI: begin q.push_back(mk(K_EXEC_I)); q.push_back(mk(K_AWB)); end
                OPL: begin q.push_back(mk(K_ADR)); q.push_back(mk(K_RD)); q.push_back(mk(K_LWB)); end
                OPS: begin q.push_back(mk(K_ADR)); q.push_back(mk(K_WR)); end
                OPB: q.push_back(mk(K_BR));
                default: begin q.push_back(mk(K_TRAP)); m_ill = 1; end
            endcase
        end
        if (q.size() == 0) q.push_back(mk(K_FETCH));
    endtask

    task automatic sample();
        ctrl_t e;
        @(negedge clk);
        e = model_expect();
        chk("model_ctrl", 64'(act), 64'(e));
        chk("model_ctrl_w2", 64'(act_w), 64'(e));
        chk("model_retired", 64'(retired), reset_n ? 64'(m_ret) : 64'd0);
        chk("model_retired_w2", 64'(w_retired), reset_n ? 64'(m_ret[1:0]) : 64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    typedef struct {
        bit          rst_n;
        logic [6:0]  opc;
        bit          z;
        bit          rdy;
        ctrl_t       exp;
        int unsigned ret;
    } vec_t;

    vec_t        tbl[18];
    logic [1:0]  seq[5];
    int unsigned hold;
    int unsigned n_ill;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        ctrl_t z0, fr, fw, dec, exr, awb, br1, br0, adr, wr;
        z0  = ctl(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0,0);
        fr  = ctl(1,0,0,1,1,0,2'b00,2'b01,2'b00,0,0,0,0);
        fw  = ctl(1,0,0,0,0,0,2'b00,2'b01,2'b00,0,0,0,0);
        dec = ctl(0,0,0,0,0,0,2'b01,2'b10,2'b00,0,0,0,0);
        exr = ctl(0,0,0,0,0,0,2'b10,2'b00,2'b10,0,0,0,0);
        awb = ctl(0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0,0);
        br1 = ctl(0,0,0,0,1,1,2'b10,2'b00,2'b01,0,0,0,0);
        br0 = ctl(0,0,0,0,0,1,2'b10,2'b00,2'b01,0,0,0,0);
        adr = ctl(0,0,0,0,0,0,2'b10,2'b10,2'b00,0,0,0,0);
        wr  = ctl(0,1,1,0,0,0,2'b00,2'b00,2'b00,0,0,0,0);

        tbl[0]  = '{0, OPR, 0, 1, z0,  0};
        tbl[1]  = '{1, OPR, 0, 1, z0,  0};
        tbl[2]  = '{1, OPR, 0, 1, fr,  0};
        tbl[3]  = '{1, OPR, 0, 1, dec, 0};
        tbl[4]  = '{1, OPR, 0, 1, exr, 0};
        tbl[5]  = '{1, OPR, 0, 1, awb, 0};
        tbl[6]  = '{1, OPB, 0, 0, fw,  1};
        tbl[7]  = '{1, OPB, 0, 1, fr,  1};
        tbl[8]  = '{1, OPB, 0, 1, dec, 1};
        tbl[9]  = '{1, OPB, 1, 1, br1, 1};
        tbl[10] = '{1, OPB, 0, 1, fr,  2};
        tbl[11] = '{1, OPB, 0, 1, dec, 2};
        tbl[12] = '{1, OPB, 0, 1, br0, 2};
        tbl[13] = '{1, OPS, 0, 1, fr,  3};
        tbl[14] = '{1, OPS, 0, 1, dec, 3};
        tbl[15] = '{1, OPS, 0, 1, adr, 3};
        tbl[16] = '{1, OPS, 0, 1, wr,  3};
        tbl[17] = '{1, OPL, 0, 1, fr,  4};
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        reset_n = 0; opcode = OPR; zero = 0; mem_ready = 1;
        model_reset();
        #1;

        // Directed vectors: reset, R-type, taken/not-taken beq, store, fetch stall.
        for (int i = 0; i < 18; i++) begin
            reset_n = tbl[i].rst_n; opcode = tbl[i].opc; zero = tbl[i].z; mem_ready = tbl[i].rdy;
            sample();
            chk($sformatf("tbl%0d_ctrl", i), 64'(act), 64'(tbl[i].exp));
            chk($sformatf("tbl%0d_retired", i), 64'(retired), 64'(tbl[i].ret));
            tick();
        end

        // Load with three wait cycles in the memory-read step.
        mem_ready = 1;
        sample(); tick();
        sample(); tick();
        hold = 0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            sample();
            if (mem_read && i_or_d) hold++;
            tick();
        end
        chk("memrd_hold_cycles", 64'(hold), 64'd4);
        mem_ready = 1;
        sample();
        chk("memwb_mem_to_reg", 64'(mem_to_reg), 64'd1);
        chk("memwb_reg_write", 64'(reg_write), 64'd1);
        tick();

        // Unsupported opcode: sticky trap, no retirement, cleared only by reset.
        opcode = 7'b1111111;
        sample(); tick();
        sample(); tick();
        n_ill = 0;
        for (int k = 0; k < 20; k++) begin
            zero = 1'($urandom_range(0, 1));
            mem_ready = 1'($urandom_range(0, 1));
            sample();
            if (illegal) n_ill++;
            tick();
        end
        chk("trap_illegal_sticky", 64'(n_ill), 64'd20);
        chk("trap_retired_frozen", 64'(retired), 64'd5);
        reset_n = 0;
        #1;
        chk("trap_reset_illegal", 64'(illegal), 64'd0);
        chk("trap_reset_retired", 64'(retired), 64'd0);
        sample(); tick();
        reset_n = 1; mem_ready = 1;
        sample(); tick();

        // Five addi on the 2-bit counter instance: 1,2,3,0,1.
        opcode = OPI;
        for (int i = 0; i < 5; i++) begin
            sample();
            if (i > 0) chk($sformatf("addi%0d_retired_w2", i - 1), 64'(w_retired), 64'(seq[i - 1]));
            tick();
            sample(); tick();
            sample();
            chk($sformatf("addi%0d_funct_sub_mask", i), 64'(funct_sub_mask), 64'd1);
            tick();
            sample(); tick();
        end
        opcode = OPS;
        sample();
        chk("addi4_retired_w2", 64'(w_retired), 64'(seq[4]));
        tick();

        // Reset pulse while a store is waiting on memory.
        sample(); tick();
        sample(); tick();
        mem_ready = 0;
        sample();
        chk("memwr_strobe", 64'(mem_write), 64'd1);
        #1;
        reset_n = 0;
        #1;
        chk("memwr_async_drop", 64'(mem_write), 64'd0);
        chk("memwr_async_iord", 64'(i_or_d), 64'd0);
        tick();
        reset_n = 1; mem_ready = 1;

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            if (q[0].kind == K_FETCH || q[0].kind == K_IDLE) begin
                case ($urandom_range(0, 15))
                    0:         opcode = 7'b0110111;
                    1, 2, 3:   opcode = OPR;
                    4, 5, 6:   opcode = OPI;
                    7, 8, 9:   opcode = OPL;
                    10, 11, 12: opcode = OPS;
                    default:   opcode = OPB;
                endcase
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            zero      = 1'($urandom_range(0, 1));
            reset_n   = !((q[0].kind == K_TRAP) || ($urandom_range(0, 99) == 0));
            sample();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
